led_rom_sequencer: RTL and testbench

- Instruction-fetch and execute front end for the LED CPU. It is the reader side of the 16-bit program ROM: it drives the ROM read address, samples the returned word, and shows the LED pattern for the encoded duration.
- It then advances to the next word, wrapping or halting at end of program.
- Sits between the combinational program ROM and the board LED pins.

---
 rtl/led_seq_pkg.sv | 27 ++
 rtl/tick_prescaler.sv | 27 ++
 rtl/led_rom_sequencer.sv | 96 +++++++++
 tb/tb_led_rom_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and instruction-word layout for the LED ROM sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  localparam int PAT_MSB = 15;
  localparam int PAT_LSB = 8;
  localparam int DUR_MSB = 7;
  localparam int DUR_LSB = 0;

  localparam logic [DATA_W-1:0] END_MARKER = 16'h0000;

  // Duration field of 0 means the full 256 ticks, hence the 9-bit result.
  function automatic logic [8:0] dur_ticks(input logic [DATA_W-1:0] word);
    logic [7:0] d;
    d = word[DUR_MSB:DUR_LSB];
    return (d == 8'd0) ? 9'd256 : {1'b0, d};
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: pulses tick on the last cycle of every TICK_DIV-cycle period while enabled.
module tick_prescaler #(
  parameter int TICK_DIV = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == TERM);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_rom_sequencer.sv
// Fetch/execute front end: reads 16-bit words from the program ROM and shows each LED pattern for its duration.
module led_rom_sequencer
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV = 1000000,
  parameter bit LOOP     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] addrRd,
  input  logic [DATA_W-1:0] dataRd,
  output logic [7:0]        leds,
  output logic              busy,
  output logic              wrap
);

  state_t     state;
  logic [8:0] remaining;
  logic       tick;
  logic       pre_clr;
  logic       pre_en;

  // Prescaler only runs in EXEC, so every instruction starts on a fresh period.
  assign pre_en  = (state == EXEC);
  assign pre_clr = stop || (state != EXEC);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (pre_en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addrRd    <= '0;
      leds      <= '0;
      busy      <= 1'b0;
      wrap      <= 1'b0;
      remaining <= '0;
    end else begin
      wrap <= 1'b0;
      if (stop) begin
        state  <= IDLE;
        addrRd <= '0;
        leds   <= '0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state  <= FETCH;
              addrRd <= '0;
              busy   <= 1'b1;
            end
          end
          FETCH: begin
            if (dataRd != END_MARKER) begin
              leds      <= dataRd[PAT_MSB:PAT_LSB];
              remaining <= dur_ticks(dataRd);
              state     <= EXEC;
            end else if ((addrRd != '0) && LOOP) begin
              addrRd <= '0;
              wrap   <= 1'b1;
            end else begin
              // A marker at address 0 always halts, so an empty program cannot spin.
              state <= IDLE;
              leds  <= '0;
              busy  <= 1'b0;
            end
          end
          EXEC: begin
            if (tick) begin
              if (remaining == 9'd1) begin
                addrRd <= addrRd + 1'b1;
                wrap   <= (addrRd == '1);
                state  <= FETCH;
              end else begin
                remaining <= remaining - 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_rom_sequencer.sv
// Scoreboard bench: three sequencer instances (TICK_DIV=2/LOOP=1, TICK_DIV=2/LOOP=0, TICK_DIV=1/LOOP=0).
module tb_led_rom_sequencer;

  typedef struct {
    int         dut;
    int         cyc;
    logic [7:0] leds;
    logic [7:0] addr;
    logic       busy;
    logic       wrap;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_v [3];
  logic        stop_v  [3];
  logic [7:0]  addr_v  [3];
  logic [15:0] data_v  [3];
  logic [7:0]  leds_v  [3];
  logic        busy_v  [3];
  logic        wrap_v  [3];

  logic [15:0] rom_ab [256];
  logic [15:0] rom_c  [256];

  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  bit  mon_en = 1'b0;
  bit  final_chk = 1'b0;
  bit  done = 1'b0;
  ev_t exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign data_v[0] = rom_ab[addr_v[0]];
  assign data_v[1] = rom_ab[addr_v[1]];
  assign data_v[2] = rom_c[addr_v[2]];

  led_rom_sequencer #(.TICK_DIV(2), .LOOP(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .stop(stop_v[0]), .addrRd(addr_v[0]),
    .dataRd(data_v[0]), .leds(leds_v[0]), .busy(busy_v[0]), .wrap(wrap_v[0]));

  led_rom_sequencer #(.TICK_DIV(2), .LOOP(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .stop(stop_v[1]), .addrRd(addr_v[1]),
    .dataRd(data_v[1]), .leds(leds_v[1]), .busy(busy_v[1]), .wrap(wrap_v[1]));

  led_rom_sequencer #(.TICK_DIV(1), .LOOP(1'b0)) dut_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .stop(stop_v[2]), .addrRd(addr_v[2]),
    .dataRd(data_v[2]), .leds(leds_v[2]), .busy(busy_v[2]), .wrap(wrap_v[2]));

  task automatic push(input int d, input int c, input logic [7:0] l, input logic [7:0] a,
                      input logic b, input logic w);
    ev_t e;
    e.dut = d; e.cyc = c; e.leds = l; e.addr = a; e.busy = b; e.wrap = w;
    exp_q.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // An event is any change of leds/busy/wrap; addr is compared but does not trigger.
  initial begin
    bit         first [3];
    logic [7:0] pl [3];
    logic       pb [3];
    logic       pw [3];
    ev_t        e;
    for (int d = 0; d < 3; d++) first[d] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && !done) begin
        for (int d = 0; d < 3; d++) begin
          if (first[d] || leds_v[d] != pl[d] || busy_v[d] != pb[d] || wrap_v[d] != pw[d]) begin
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL unexpected_event dut%0d cyc=%0d got leds=%h addr=%h busy=%b wrap=%b",
                       d, cyc, leds_v[d], addr_v[d], busy_v[d], wrap_v[d]);
            end else begin
              e = exp_q.pop_front();
              if (e.dut != d || e.cyc != cyc || e.leds !== leds_v[d] || e.addr !== addr_v[d] ||
                  e.busy !== busy_v[d] || e.wrap !== wrap_v[d]) begin
                bad++;
                $display("FAIL event got dut%0d cyc=%0d leds=%h addr=%h busy=%b wrap=%b, want dut%0d cyc=%0d leds=%h addr=%h busy=%b wrap=%b",
                         d, cyc, leds_v[d], addr_v[d], busy_v[d], wrap_v[d],
                         e.dut, e.cyc, e.leds, e.addr, e.busy, e.wrap);
              end
            end
          end
          first[d] = 1'b0;
          pl[d] = leds_v[d];
          pb[d] = busy_v[d];
          pw[d] = wrap_v[d];
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          total++;
          bad++;
          $display("FAIL missed_event dut%0d want cyc=%0d leds=%h addr=%h busy=%b wrap=%b, now cyc=%0d",
                   e.dut, e.cyc, e.leds, e.addr, e.busy, e.wrap, cyc);
        end
        if (final_chk) begin
          total++;
          if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got %0d pending, want 0", exp_q.size());
          end
          done = 1'b1;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got cyc=%0d, want finish before time limit", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s2;
    for (int d = 0; d < 3; d++) begin start_v[d] = 1'b0; stop_v[d] = 1'b0; end
    for (int i = 0; i < 256; i++) begin rom_ab[i] = 16'h0000; rom_c[i] = 16'h0000; end
    for (int k = 0; k < 8; k++) rom_ab[k] = {8'h80 >> k, 8'h80};

    // Reset state of all three instances
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) push(d, cyc + 1, 8'h00, 8'h00, 1'b0, 1'b0);
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    // A: walking bit, LOOP=1, wrap via end marker, ignored start, stop mid-EXEC
    s = cyc + 1;
    push(0, s, 8'h00, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) push(0, s + 1 + 257 * k, 8'h80 >> k, 8'(k), 1'b1, 1'b0);
    push(0, s + 2057, 8'h01, 8'h00, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) push(0, s + 2058 + 257 * k, 8'h80 >> k, 8'(k), 1'b1, 1'b0);
    push(0, s + 2900, 8'h00, 8'h00, 1'b0, 1'b0);
    start_v[0] = 1'b1; @(negedge clk); start_v[0] = 1'b0;
    wait_to(s + 499);
    start_v[0] = 1'b1; @(negedge clk); start_v[0] = 1'b0;
    wait_to(s + 2899);
    stop_v[0] = 1'b1; @(negedge clk); stop_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    start_v[0] = 1'b1; stop_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0; stop_v[0] = 1'b0;
    repeat (10) @(negedge clk);

    // B: LOOP=0 halts at the marker keeping addr=8; restart; reset mid-EXEC
    s = cyc + 1;
    push(1, s, 8'h00, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) push(1, s + 1 + 257 * k, 8'h80 >> k, 8'(k), 1'b1, 1'b0);
    push(1, s + 2057, 8'h00, 8'h08, 1'b0, 1'b0);
    start_v[1] = 1'b1; @(negedge clk); start_v[1] = 1'b0;
    wait_to(s + 2062);
    s2 = cyc + 1;
    push(1, s2, 8'h00, 8'h00, 1'b1, 1'b0);
    push(1, s2 + 1, 8'h80, 8'h00, 1'b1, 1'b0);
    push(1, s2 + 50, 8'h00, 8'h00, 1'b0, 1'b0);
    start_v[1] = 1'b1; @(negedge clk); start_v[1] = 1'b0;
    wait_to(s2 + 49);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk);

    // C1: 16'hFF00 with TICK_DIV=1 -> 1 fetch + 256 exec cycles, then marker halts at addr 1
    rom_c[0] = 16'hFF00;
    s = cyc + 1;
    push(2, s, 8'h00, 8'h00, 1'b1, 1'b0);
    push(2, s + 1, 8'hFF, 8'h00, 1'b1, 1'b0);
    push(2, s + 258, 8'h00, 8'h01, 1'b0, 1'b0);
    start_v[2] = 1'b1; @(negedge clk); start_v[2] = 1'b0;
    wait_to(s + 265);

    // C2: empty program -> one FETCH cycle, back to IDLE, no wrap
    rom_c[0] = 16'h0000;
    s = cyc + 1;
    push(2, s, 8'h00, 8'h00, 1'b1, 1'b0);
    push(2, s + 1, 8'h00, 8'h00, 1'b0, 1'b0);
    start_v[2] = 1'b1; @(negedge clk); start_v[2] = 1'b0;
    wait_to(s + 5);

    // C3: 256 x 16'h0101, 2 cycles per word, address rollover wraps without halting
    for (int i = 0; i < 256; i++) rom_c[i] = 16'h0101;
    s = cyc + 1;
    push(2, s, 8'h00, 8'h00, 1'b1, 1'b0);
    push(2, s + 1, 8'h01, 8'h00, 1'b1, 1'b0);
    push(2, s + 512, 8'h01, 8'h00, 1'b1, 1'b1);
    push(2, s + 513, 8'h01, 8'h00, 1'b1, 1'b0);
    push(2, s + 1024, 8'h01, 8'h00, 1'b1, 1'b1);
    push(2, s + 1025, 8'h01, 8'h00, 1'b1, 1'b0);
    push(2, s + 1100, 8'h00, 8'h00, 1'b0, 1'b0);
    start_v[2] = 1'b1; @(negedge clk); start_v[2] = 1'b0;
    wait_to(s + 1099);
    stop_v[2] = 1'b1; @(negedge clk); stop_v[2] = 1'b0;
    repeat (10) @(negedge clk);

    final_chk = 1'b1;
    for (int i = 0; i < 10 && !done; i++) @(negedge clk);
    if (!done) begin
      $display("FAIL monitor_done got done=0, want 1");
      $fatal(1, "monitor stalled");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
